pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_pkg.sv | 28 ++
 rtl/sync2ff.sv | 23 ++
 rtl/pll_lock_ctrl.sv | 118 +++++++++++
 tb/tb_pll_lock_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock controller: state encoding,
// charge-pump base selection and lock-qualification constants.
package pll_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_LOCKED,
        ST_FAIL
    } pll_state_t;

    localparam logic [2:0] LPFRES_BASE   = 3'd2;
    localparam int         LOSS_FILT_LEN = 4;
    localparam logic [1:0] ATTEMPT_LAST  = 2'd3;

    // Higher feedback multipliers need a stronger starting charge-pump current.
    function automatic logic [5:0] icp_base(input int multi_fac);
        return (multi_fac <= 16) ? 6'd16 : 6'd24;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Latency: 2 clk cycles from input change to q.
// Backpressure: none; samples every cycle.
module sync2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset pulse, lock wait, stability qualification, retries with stronger loop settings.
// Latency: all outputs registered, one init_clk after the state decision; pll_lock adds 2 cycles of sync.
// Backpressure: none; retry is only honoured in FAIL and ignored elsewhere.
module pll_lock_ctrl
    import pll_pkg::*;
#(
    parameter int CLK_PERIOD    = 20,
    parameter int MULTI_FAC     = 10,
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 256
) (
    input  logic       init_clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       retry,
    output logic       pll_rst,
    output logic [5:0] icpsel,
    output logic [2:0] lpfres,
    output logic       lock,
    output logic       fail,
    output logic [1:0] attempt
);

    localparam int               CNT_MAX   = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int               CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_FILT_LEN - 1);
    localparam logic [5:0]       ICP_BASE  = icp_base(MULTI_FAC);

    if (CLK_PERIOD < 1 || RST_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1) begin : g_bad_param
        $error("pll_lock_ctrl: timing parameters must be positive");
    end

    pll_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       attempt_nxt;
    logic             attempt_fail;
    logic             lock_s;

    sync2ff u_lock_sync (
        .clk   (init_clk),
        .rst_n (resetn),
        .d     (pll_lock),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_ONE;
        attempt_nxt  = attempt;
        attempt_fail = 1'b0;
        case (state)
            ST_RST: begin
                if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s)                 state_nxt    = ST_STABLE;
                else if (cnt == TMO_LAST)   attempt_fail = 1'b1;
            end
            ST_STABLE: begin
                if (!lock_s)                attempt_fail = 1'b1;
                else if (cnt == STB_LAST)   state_nxt    = ST_LOCKED;
            end
            ST_LOCKED: begin
                // cnt tracks consecutive low samples; any high sample restarts the filter
                if (lock_s)                 cnt_nxt   = '0;
                else if (cnt == LOSS_LAST)  state_nxt = ST_RST;
            end
            ST_FAIL: begin
                cnt_nxt = '0;
                if (retry) begin
                    state_nxt   = ST_RST;
                    attempt_nxt = 2'd0;
                end
            end
            default: state_nxt = ST_RST;
        endcase

        if (attempt_fail) begin
            if (attempt == ATTEMPT_LAST) begin
                state_nxt = ST_FAIL;
            end else begin
                state_nxt   = ST_RST;
                attempt_nxt = attempt + 2'd1;
            end
        end

        if (state_nxt != state) cnt_nxt = '0;
    end

    // Outputs decode the next state so they change on the same edge as the state register.
    always_ff @(posedge init_clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_RST;
            cnt     <= '0;
            attempt <= 2'd0;
            pll_rst <= 1'b1;
            lock    <= 1'b0;
            fail    <= 1'b0;
            icpsel  <= ICP_BASE;
            lpfres  <= LPFRES_BASE;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            attempt <= attempt_nxt;
            pll_rst <= (state_nxt == ST_RST);
            lock    <= (state_nxt == ST_LOCKED);
            fail    <= (state_nxt == ST_FAIL);
            icpsel  <= ICP_BASE + {2'b00, attempt_nxt, 2'b00};
            lpfres  <= LPFRES_BASE + {1'b0, attempt_nxt};
        end
    end

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: a default-parameter instance for lock timing/filtering and a
// shortened-timeout MULTI_FAC=20 instance for the retry ladder, FAIL and retry.
module tb_pll_lock_ctrl;

    localparam int D_MF = 10, D_RST = 64, D_TMO = 50000, D_STB = 256;
    localparam int F_MF = 20, F_RST = 16, F_TMO = 300,   F_STB = 40;
    localparam int SYNC_LAT = 2;
    localparam int LOSS_LEN = 4;

    logic       clk;
    logic       rstn_d, lk_d, rt_d, pll_rst_d, lock_d, fail_d;
    logic [5:0] icp_d;
    logic [2:0] lpf_d;
    logic [1:0] att_d;
    logic       rstn_f, lk_f, rt_f, pll_rst_f, lock_f, fail_f;
    logic [5:0] icp_f;
    logic [2:0] lpf_f;
    logic [1:0] att_f;

    int n_cmp = 0;
    int n_bad = 0;

    pll_lock_ctrl #(
        .CLK_PERIOD(20), .MULTI_FAC(D_MF), .RST_CYCLES(D_RST),
        .LOCK_TIMEOUT(D_TMO), .STABLE_CYCLES(D_STB)
    ) dut_d (
        .init_clk(clk), .resetn(rstn_d), .pll_lock(lk_d), .retry(rt_d),
        .pll_rst(pll_rst_d), .icpsel(icp_d), .lpfres(lpf_d),
        .lock(lock_d), .fail(fail_d), .attempt(att_d)
    );

    pll_lock_ctrl #(
        .CLK_PERIOD(20), .MULTI_FAC(F_MF), .RST_CYCLES(F_RST),
        .LOCK_TIMEOUT(F_TMO), .STABLE_CYCLES(F_STB)
    ) dut_f (
        .init_clk(clk), .resetn(rstn_f), .pll_lock(lk_f), .retry(rt_f),
        .pll_rst(pll_rst_f), .icpsel(icp_f), .lpfres(lpf_f),
        .lock(lock_f), .fail(fail_f), .attempt(att_f)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Expected output bundle {pll_rst, lock, fail, attempt, icpsel, lpfres} from the loop-setting rules.
    function automatic logic [13:0] exp_vec(input logic r, input logic l, input logic f,
                                            input int a, input int mf);
        int icp;
        icp = ((mf <= 16) ? 16 : 24) + 4 * a;
        return {r, l, f, 2'(a), 6'(icp), 3'(2 + a)};
    endfunction

    function automatic logic [13:0] obs_d();
        return {pll_rst_d, lock_d, fail_d, att_d, icp_d, lpf_d};
    endfunction

    function automatic logic [13:0] obs_f();
        return {pll_rst_f, lock_f, fail_f, att_f, icp_f, lpf_f};
    endfunction

    // Reset the default instance, release, and raise pll_lock d cycles after pll_rst falls.
    task automatic run_to_lock_d(input int d, output int n_rst, output int n_lock);
        lk_d = 1'b0;
        rstn_d = 1'b0;
        @(negedge clk);
        rstn_d = 1'b1;
        n_rst = 0;
        do begin @(negedge clk); n_rst++; end while (pll_rst_d && n_rst < 1000);
        repeat (d) @(negedge clk);
        lk_d = 1'b1;
        n_lock = 0;
        do begin @(negedge clk); n_lock++; end while (!lock_d && n_lock < D_STB + 50);
    endtask

    task automatic test_reset();
        rstn_d = 1'b0; rstn_f = 1'b0;
        lk_d = 1'b0; lk_f = 1'b0; rt_d = 1'b0; rt_f = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs_d() !== exp_vec(1'b1, 1'b0, 1'b0, 0, D_MF)) begin
            n_bad++; $display("FAIL reset_default: got %h, expected %h", obs_d(), exp_vec(1'b1, 1'b0, 1'b0, 0, D_MF));
        end
        n_cmp++;
        if (obs_f() !== exp_vec(1'b1, 1'b0, 1'b0, 0, F_MF)) begin
            n_bad++; $display("FAIL reset_multifac20: got %h, expected %h", obs_f(), exp_vec(1'b1, 1'b0, 1'b0, 0, F_MF));
        end
    endtask

    task automatic test_lock_acquire();
        for (int it = 0; it < 2; it++) begin
            int d, nr, nl;
            d = (it == 0) ? 100 : int'($urandom_range(1, 300));
            run_to_lock_d(d, nr, nl);
            n_cmp++;
            if (nr !== D_RST) begin
                n_bad++; $display("FAIL acq_rst_len: got %0d, expected %0d", nr, D_RST);
            end
            n_cmp++;
            if (nl < SYNC_LAT + D_STB - 1 || nl > SYNC_LAT + D_STB + 1) begin
                n_bad++; $display("FAIL acq_lock_latency: got %0d, expected %0d +-1", nl, SYNC_LAT + D_STB);
            end
            n_cmp++;
            if (obs_d() !== exp_vec(1'b0, 1'b1, 1'b0, 0, D_MF)) begin
                n_bad++; $display("FAIL acq_locked_outs: got %h, expected %h", obs_d(), exp_vec(1'b0, 1'b1, 1'b0, 0, D_MF));
            end
        end
    endtask

    task automatic test_glitch_stable();
        int d, g, n;
        logic saw_lock;
        d = $urandom_range(1, 200);
        g = $urandom_range(6, D_STB - 20);
        lk_d = 1'b0;
        rstn_d = 1'b0;
        @(negedge clk);
        rstn_d = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (pll_rst_d && n < 1000);
        repeat (d) @(negedge clk);
        lk_d = 1'b1;
        saw_lock = 1'b0;
        repeat (g) begin @(negedge clk); saw_lock |= lock_d; end
        lk_d = 1'b0;
        @(negedge clk);
        lk_d = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; saw_lock |= lock_d; end while (!pll_rst_d && n < 10);
        lk_d = 1'b0;
        n_cmp++;
        if (n >= 10 || saw_lock !== 1'b0) begin
            n_bad++; $display("FAIL glitch_reaction: got rst_wait=%0d lock_seen=%0b, expected rst within 10 and lock_seen=0", n, saw_lock);
        end
        n_cmp++;
        if (obs_d() !== exp_vec(1'b1, 1'b0, 1'b0, 1, D_MF)) begin
            n_bad++; $display("FAIL glitch_next_attempt: got %h, expected %h", obs_d(), exp_vec(1'b1, 1'b0, 1'b0, 1, D_MF));
        end
        n = 0;
        do begin @(negedge clk); n++; end while (pll_rst_d && n < 1000);
        n_cmp++;
        if (n !== D_RST) begin
            n_bad++; $display("FAIL glitch_rst_len: got %0d, expected %0d", n, D_RST);
        end
    endtask

    // Continues from the glitch test: dut_d sits in WAIT_LOCK on attempt 1.
    task automatic test_async_reset();
        int n;
        repeat ($urandom_range(5, 200)) @(negedge clk);
        n_cmp++;
        if (obs_d() !== exp_vec(1'b0, 1'b0, 1'b0, 1, D_MF)) begin
            n_bad++; $display("FAIL async_pre_wait: got %h, expected %h", obs_d(), exp_vec(1'b0, 1'b0, 1'b0, 1, D_MF));
        end
        #3 rstn_d = 1'b0;
        #1;
        n_cmp++;
        if (obs_d() !== exp_vec(1'b1, 1'b0, 1'b0, 0, D_MF)) begin
            n_bad++; $display("FAIL async_reset_values: got %h, expected %h", obs_d(), exp_vec(1'b1, 1'b0, 1'b0, 0, D_MF));
        end
        @(negedge clk);
        rstn_d = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (pll_rst_d && n < 1000);
        n_cmp++;
        if (n !== D_RST) begin
            n_bad++; $display("FAIL async_restart_rst_len: got %0d, expected %0d", n, D_RST);
        end
    endtask

    task automatic test_loss_filter();
        int nr, nl;
        run_to_lock_d($urandom_range(1, 100), nr, nl);
        n_cmp++;
        if (lock_d !== 1'b1) begin
            n_bad++; $display("FAIL loss_setup_lock: got %0b, expected 1", lock_d);
        end
        for (int i = 0; i < 8; i++) begin
            int len, k, n, a;
            logic rs;
            len = (i == 0) ? 3 : (i == 1) ? 4 : int'($urandom_range(1, 6));
            a = 0;
            k = -1;
            rs = 1'b0;
            lk_d = 1'b0;
            for (int c = 1; c <= len + 8; c++) begin
                @(negedge clk);
                if (c == len) lk_d = 1'b1;
                if (k < 0 && !lock_d) begin k = c; rs = pll_rst_d; end
            end
            if (len >= LOSS_LEN) begin
                n_cmp++;
                if (k < LOSS_LEN + SYNC_LAT - 1 || k > LOSS_LEN + SYNC_LAT + 1 || rs !== 1'b1) begin
                    n_bad++; $display("FAIL loss_drop len=%0d: got at=%0d pll_rst=%0b, expected at=%0d+-1 pll_rst=1", len, k, rs, LOSS_LEN + SYNC_LAT);
                end
                n = 0;
                do begin @(negedge clk); n++; end while (!lock_d && n < 2000);
                n_cmp++;
                if (lock_d !== 1'b1 || att_d !== 2'(a)) begin
                    n_bad++; $display("FAIL loss_relock: got lock=%0b attempt=%0d, expected lock=1 attempt=%0d", lock_d, att_d, a);
                end
            end else begin
                n_cmp++;
                if (k !== -1) begin
                    n_bad++; $display("FAIL loss_short_ignored len=%0d: got drop at %0d, expected no drop", len, k);
                end
            end
        end
    endtask

    task automatic test_timeout_retry();
        int n;
        lk_f = 1'b0;
        rt_f = 1'b0;
        rstn_f = 1'b0;
        @(negedge clk);
        rstn_f = 1'b1;
        for (int a = 0; a < 4; a++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (pll_rst_f && n < 1000);
            n_cmp++;
            if (n !== F_RST) begin
                n_bad++; $display("FAIL to_rst_len a=%0d: got %0d, expected %0d", a, n, F_RST);
            end
            n_cmp++;
            if (obs_f() !== exp_vec(1'b0, 1'b0, 1'b0, a, F_MF)) begin
                n_bad++; $display("FAIL to_wait_outs a=%0d: got %h, expected %h", a, obs_f(), exp_vec(1'b0, 1'b0, 1'b0, a, F_MF));
            end
            n = 0;
            do begin
                @(negedge clk);
                n++;
                rt_f = (a == 1 && n == 50);
            end while (!pll_rst_f && !fail_f && n < 1000);
            rt_f = 1'b0;
            n_cmp++;
            if (n !== F_TMO) begin
                n_bad++; $display("FAIL to_timeout_len a=%0d: got %0d, expected %0d", a, n, F_TMO);
            end
        end
        n_cmp++;
        if (obs_f() !== exp_vec(1'b0, 1'b0, 1'b1, 3, F_MF)) begin
            n_bad++; $display("FAIL to_fail_outs: got %h, expected %h", obs_f(), exp_vec(1'b0, 1'b0, 1'b1, 3, F_MF));
        end
        repeat ($urandom_range(3, 40)) @(negedge clk);
        n_cmp++;
        if (obs_f() !== exp_vec(1'b0, 1'b0, 1'b1, 3, F_MF)) begin
            n_bad++; $display("FAIL to_fail_hold: got %h, expected %h", obs_f(), exp_vec(1'b0, 1'b0, 1'b1, 3, F_MF));
        end
        rt_f = 1'b1;
        @(negedge clk);
        rt_f = 1'b0;
        n_cmp++;
        if (obs_f() !== exp_vec(1'b1, 1'b0, 1'b0, 0, F_MF)) begin
            n_bad++; $display("FAIL to_retry_outs: got %h, expected %h", obs_f(), exp_vec(1'b1, 1'b0, 1'b0, 0, F_MF));
        end
        n = 0;
        do begin @(negedge clk); n++; end while (pll_rst_f && n < 1000);
        n_cmp++;
        if (n !== F_RST) begin
            n_bad++; $display("FAIL to_retry_rst_len: got %0d, expected %0d", n, F_RST);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_glitch_stable();
        test_async_reset();
        test_loss_filter();
        test_timeout_retry();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
